// File: rtl/sad_search_ctrl.sv
// Block-matching search controller: launches one SAD computation per candidate,
// keeps the minimum SAD and its index, and aborts if the engine never completes.
module sad_search_ctrl #(
  parameter int N_CAND  = 16,
  parameter int SAD_W   = 16,
  parameter int TIMEOUT = 1024,
  localparam int IDX_W  = $clog2(N_CAND)
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             sad_enb_o,
  input  logic             sad_busy_i,
  input  logic [SAD_W-1:0] sad_val_i,
  output logic [IDX_W-1:0] cand_o,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [IDX_W-1:0] best_idx_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             enb_q, enb_d;
  logic             done_q, done_d;
  logic             last_cand_s;
  logic             take_s;

  assign last_cand_s = (cand_q == IDX_W'(N_CAND - 1));
  // Candidate 0 always seeds the minimum; later ones replace it only when strictly smaller.
  assign take_s      = (cand_q == {IDX_W{1'b0}}) || (sad_val_i < best_sad_q);

  // Next-state, datapath and Moore output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    best_idx_d = best_idx_q;
    best_sad_d = best_sad_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LAUNCH;
          cand_d  = {IDX_W{1'b0}};
          err_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!sad_busy_i) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_CAPTURE: begin
        if (take_s) begin
          best_sad_d = sad_val_i;
          best_idx_d = cand_q;
        end else begin
          best_sad_d = best_sad_q;
        end
        if (last_cand_s) begin
          state_d = S_DONE;
        end else begin
          cand_d  = cand_q + IDX_W'(1);
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
    enb_d  = (state_d == S_LAUNCH);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      cand_q     <= {IDX_W{1'b0}};
      best_idx_q <= {IDX_W{1'b0}};
      best_sad_q <= {SAD_W{1'b0}};
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      enb_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      best_idx_q <= best_idx_d;
      best_sad_q <= best_sad_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      enb_q      <= enb_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign sad_enb_o  = enb_q;
  assign cand_o     = cand_q;
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: behavioural SAD engine plus a schedule-based reference
// model checked every cycle, with directed scenarios and randomized searches.
module tb_sad_search_ctrl;
  localparam int N  = 4;
  localparam int SW = 16;
  localparam int TO = 1024;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, err_o, sad_enb_o;
  logic          sad_busy_i;
  logic [SW-1:0] sad_val_i;
  logic [IW-1:0] cand_o, best_idx_o;
  logic [SW-1:0] best_sad_o;

  sad_search_ctrl #(.N_CAND(N), .SAD_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn_i(rstn_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .sad_enb_o(sad_enb_o), .sad_busy_i(sad_busy_i), .sad_val_i(sad_val_i),
    .cand_o(cand_o), .best_sad_o(best_sad_o), .best_idx_o(best_idx_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int            w_tab [N];
  logic [SW-1:0] v_tab [N];
  int            enb_q [$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: W cycles after a launch, busy drops for one cycle with the result.
  int eng = 0;
  initial begin
    sad_busy_i = 1'b1;
    sad_val_i  = '0;
    forever begin
      tick();
      if (!rstn_i) begin
        eng = 0;
        sad_busy_i = 1'b1;
      end else if (sad_enb_o) begin
        eng = w_tab[cand_o];
        sad_busy_i = 1'($urandom_range(0, 1));
      end else if (eng > 0) begin
        eng--;
        if (eng == 0) begin
          sad_busy_i = 1'b0;
          sad_val_i  = v_tab[cand_o];
        end else begin
          sad_busy_i = 1'b1;
        end
      end else begin
        sad_busy_i = 1'b1;
      end
    end
  end

  // Reference model: an accepted start fixes the whole search timeline up front.
  int cyc = 0, t0 = 0, done_cyc = 0, n_launch = 0, n_cap = 0, lpos = 0;
  int launch [N];
  int cap    [N];
  logic [SW-1:0] sv [N];
  bit   act = 0, sch_err = 0;
  logic [SW-1:0] best_m = '0;
  logic [IW-1:0] idx_m = '0, cand_m = '0;
  logic busy_m, enb_m, done_m, err_m = 1'b0;

  always @(negedge clk) begin
    cyc++;
    busy_m = 1'b0; enb_m = 1'b0; done_m = 1'b0;
    if (!rstn_i) begin
      act = 0; best_m = '0; idx_m = '0; cand_m = '0; err_m = 1'b0;
    end else begin
      if (act && cyc > done_cyc) act = 0;
      if (act) begin
        busy_m = (cyc < done_cyc);
        done_m = (cyc == done_cyc);
        if (cyc == t0 + 1) err_m = 1'b0;
        if (cyc == done_cyc) err_m = sch_err;
        for (int k = 0; k < n_cap; k++)
          if (cyc == cap[k] + 1 && (k == 0 || sv[k] < best_m)) begin
            best_m = sv[k];
            idx_m  = IW'(k);
          end
        for (int k = 0; k < n_launch; k++) begin
          if (cyc == launch[k]) enb_m = 1'b1;
          if (cyc >= launch[k]) cand_m = IW'(k);
        end
      end
    end
    check("busy_o", 32'(busy_o), 32'(busy_m));
    check("done_o", 32'(done_o), 32'(done_m));
    check("sad_enb_o", 32'(sad_enb_o), 32'(enb_m));
    check("err_o", 32'(err_o), 32'(err_m));
    check("cand_o", 32'(cand_o), 32'(cand_m));
    check("best_sad_o", 32'(best_sad_o), 32'(best_m));
    check("best_idx_o", 32'(best_idx_o), 32'(idx_m));
    if (rstn_i && start_i && !act) begin
      act = 1; t0 = cyc; lpos = cyc + 1; n_launch = 0; n_cap = 0; sch_err = 0;
      for (int k = 0; k < N; k++) begin
        sv[k] = v_tab[k];
        launch[k] = lpos;
        n_launch++;
        if (w_tab[k] > TO) begin
          sch_err = 1;
          done_cyc = lpos + TO + 1;
          break;
        end
        cap[k] = lpos + w_tab[k] + 1;
        n_cap++;
        lpos = lpos + w_tab[k] + 2;
        done_cyc = cap[k] + 1;
      end
    end
  end

  // Start a search in IDLE and follow it to done_o; done_at counts cycles after the first launch cycle.
  task automatic run_search(input int poke_at, input bit poke_done, output int done_at);
    enb_q.delete();
    done_at = -1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (sad_enb_o) enb_q.push_back(i);
      if (done_o) begin
        done_at = i;
        break;
      end
      start_i = (i == poke_at);
      tick();
    end
    start_i = 1'b0;
    check("done_within_bound", 32'(done_at >= 0), 32'd1);
    if (poke_done) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
  endtask

  function automatic int expected_latency();
    int s = 0;
    for (int k = 0; k < N; k++) s += w_tab[k] + 2;
    return s;
  endfunction

  int da;
  initial begin
    for (int k = 0; k < N; k++) begin w_tab[k] = 4; v_tab[k] = '0; end
    #2 rstn_i = 1'b0;
    repeat (3) tick();
    check("reset_state", {8'd0, busy_o, done_o, sad_enb_o, err_o, cand_o, best_sad_o, best_idx_o}, 32'd0);
    rstn_i = 1'b1;
    tick();

    // Normal search with a 256-pixel engine: 517-cycle candidate period
    for (int k = 0; k < N; k++) w_tab[k] = 515;
    v_tab[0] = 16'd300; v_tab[1] = 16'd120; v_tab[2] = 16'd500; v_tab[3] = 16'd90;
    run_search(-1, 1'b0, da);
    check("normal_latency", 32'(da), 32'd2068);
    check("normal_best_sad", 32'(best_sad_o), 32'd90);
    check("normal_best_idx", 32'(best_idx_o), 32'd3);
    check("normal_err", 32'(err_o), 32'd0);
    check("normal_launches", 32'(enb_q.size()), 32'd4);
    for (int k = 1; k < enb_q.size(); k++)
      check("launch_period", 32'(enb_q[k] - enb_q[k-1]), 32'd517);
    tick();

    // Ties keep the earliest index; 65535 seeds the minimum
    for (int k = 0; k < N; k++) w_tab[k] = $urandom_range(1, 10);
    v_tab[0] = 16'd65535; v_tab[1] = 16'd40; v_tab[2] = 16'd40; v_tab[3] = 16'd70;
    run_search(-1, 1'b0, da);
    check("tie_best_sad", 32'(best_sad_o), 32'd40);
    check("tie_best_idx", 32'(best_idx_o), 32'd1);
    tick();

    // Starts during WAIT and on the done_o cycle must be ignored
    for (int k = 0; k < N; k++) begin w_tab[k] = 20; v_tab[k] = 16'(100 + k); end
    run_search(5, 1'b1, da);
    check("ignored_start_latency", 32'(da), 32'd88);
    check("ignored_start_launches", 32'(enb_q.size()), 32'd4);
    for (int i = 0; i < 8; i++) begin
      check("idle_after_done", {30'd0, busy_o, sad_enb_o}, 32'd0);
      tick();
    end

    // Candidate 2 never completes: abort after TIMEOUT wait cycles
    w_tab[0] = 5; w_tab[1] = 7; w_tab[2] = 3000; w_tab[3] = 4;
    v_tab[0] = 16'd50; v_tab[1] = 16'd30; v_tab[2] = 16'd1; v_tab[3] = 16'd2;
    run_search(-1, 1'b0, da);
    check("timeout_latency", 32'(da), 32'd1041);
    check("timeout_err", 32'(err_o), 32'd1);
    check("timeout_cand", 32'(cand_o), 32'd2);
    check("timeout_best_sad", 32'(best_sad_o), 32'd30);
    check("timeout_best_idx", 32'(best_idx_o), 32'd1);
    tick();
    for (int k = 0; k < N; k++) begin w_tab[k] = 3; v_tab[k] = 16'(900 - k); end
    run_search(-1, 1'b0, da);
    check("err_cleared", 32'(err_o), 32'd0);
    check("after_timeout_best_idx", 32'(best_idx_o), 32'd3);

    // Back-to-back: start in the IDLE cycle right after done_o
    tick();
    for (int k = 0; k < N; k++) begin w_tab[k] = 6; v_tab[k] = 16'(7000 + 10 * k); end
    run_search(-1, 1'b0, da);
    check("b2b_best_sad", 32'(best_sad_o), 32'd7000);
    check("b2b_best_idx", 32'(best_idx_o), 32'd0);

    // Reset in the middle of WAIT: outputs clear immediately, no done_o follows
    tick();
    for (int k = 0; k < N; k++) w_tab[k] = 30;
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (10) tick();
    rstn_i = 1'b0;
    #1;
    check("reset_mid_wait", {8'd0, busy_o, done_o, sad_enb_o, err_o, cand_o, best_sad_o, best_idx_o}, 32'd0);
    repeat (3) tick();
    rstn_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("no_done_after_reset", {30'd0, done_o, busy_o}, 32'd0);
      tick();
    end

    // Randomized searches with random gaps between them
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < N; k++) begin
        w_tab[k] = $urandom_range(1, 12);
        v_tab[k] = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(0, 7)) : SW'($urandom);
      end
      run_search(-1, 1'b0, da);
      check("rand_latency", 32'(da), 32'(expected_latency()));
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
